ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
- PS/2 device-to-host receiver. Samples the raw keyboard ps2_clk/ps2_data pins in the board_clk domain and deserialises 11-bit frames.
- Checks parity and stop bit, tracks the E0 (extended) and F0 (break) prefixes, and emits one qualified scan-code event per key action.
- Sits directly upstream of kb2game, which consumes the events to build the p1/p2 control vectors.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data.
- FILTER_LEN, 8, consecutive equal board_clk samples needed before filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 100000, board_clk cycles without a falling ps2_clk edge before a partial frame is aborted.

Ports:
- board_clk  in  1  system clock. All logic is on this single clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idles high.
- ps2_data  in  1  raw PS/2 data pin, asynchronous, idles high.
- scan_code  out  8  last decoded scan code, excluding prefix bytes.
- scan_valid  out  1  one-cycle pulse; scan_code, is_break and is_extended are valid this cycle.
- is_break  out  1  event was preceded by F0.
- is_extended  out  1  event was preceded by E0.
- parity_err  out  1  one-cycle pulse on an odd-parity failure.
- frame_err  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout.

Behaviour:
- Reset, synchronous and active-high:
  - synchroniser flops = 1 and filtered clock = 1;
  - FSM = IDLE; bit counter, shift register and timeout counter = 0;
  - prefix flags cleared;
  - all outputs = 0.
  - Reset mid-frame discards the partial frame with no error pulse.
- Front end:
  - Both pins pass through SYNC_STAGES flops.
  - ps2_clk is then glitch-filtered: the filtered level changes only after FILTER_LEN identical consecutive samples.
  - fall = filtered level was 1 in the previous cycle and is 0 now, a one-cycle strobe.
  - Data is sampled from synchronised ps2_data, delayed so that it is aligned with fall.
- Frame FSM, advancing only on fall (except timeout):
  - IDLE: on fall with data=0, go to DATA with bit_cnt=0. On fall with data=1, pulse frame_err and stay in IDLE.
  - DATA: shift the data bit in LSB-first and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit and go to STOP.
  - STOP, on fall:
    - If the 8 data bits plus the parity bit do not have odd parity: pulse parity_err and clear both prefix flags.
    - Otherwise, if stop bit = 0: pulse frame_err and clear both prefix flags.
    - Otherwise: deliver the byte to the decoder.
    - In every case, return to IDLE.
- Timeout:
  - The counter clears on every fall and counts while the FSM is not IDLE.
  - At TIMEOUT_CYCLES: pulse frame_err, go to IDLE, clear both prefix flags.
  - The counter saturates and does not wrap.
- Decoder, acting on the cycle after a good frame:
  - byte 0xE0: set ext_flag, no output.
  - byte 0xF0: set brk_flag, no output.
  - Any other byte, including 0xE1: drive scan_code=byte, is_break=brk_flag, is_extended=ext_flag, pulse scan_valid for 1 cycle, then clear both flags.
  - Repeated prefixes are idempotent.
- Latency: scan_valid rises exactly 1 board_clk cycle after the fall strobe of the stop bit.
  - scan_code, is_break and is_extended hold their value until the next scan_valid.
  - parity_err and frame_err pulses have the same 1-cycle latency as scan_valid.
- Simultaneous events: when fall and the timeout terminal count occur in the same cycle, fall wins and the timeout is ignored.
- No host-to-device transmission. Both pins are inputs only.

Decomposition:
- Package ps2_pkg contains:
  - PS2_EXT_PREFIX = 8'hE0 and PS2_BRK_PREFIX = 8'hF0;
  - the FSM state encoding: IDLE, DATA, PARITY, STOP;
  - the frame bit-count constant 8.
- One sub-module, ps2_clk_filter, holds the synchroniser, glitch filter and falling-edge strobe. It outputs fall and aligned data.
- The frame FSM, timeout counter and decoder stay in ps2_scancode_rx.

Test Plan:
- Send frame 0x1D (odd-parity bit 1, stop 1) at 12.5 kHz PS/2 clock -> exactly one scan_valid, scan_code=0x1D, is_break=0, is_extended=0, no error pulses.
- Send F0 then 1D -> one scan_valid only, scan_code=0x1D, is_break=1, is_extended=0. A following 1D frame -> is_break=0.
- Send E0, F0, 75 -> one scan_valid, scan_code=0x75, is_break=1, is_extended=1. A following 75 frame -> both flags 0.
- Send 0x1C with a flipped parity bit -> parity_err pulse, no scan_valid. A subsequent valid 0x1C -> scan_valid with scan_code=0x1C.
- Send E0, then start + 4 data bits, then idle longer than TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE. A following 0x6B frame -> scan_valid with is_extended=0 (prefix cleared).
- Inject a low ps2_clk glitch of FILTER_LEN-1 cycles in IDLE -> no state change, no pulses. Assert reset at bit 5 of a frame, then send 0x29 -> only 0x29 is reported, no error pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame FSM encoding for the PS/2 scan-code receiver
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // True when the data byte plus its parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par);
    return ^{data_byte, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - pin synchronisers, ps2_clk glitch filter and falling-edge strobe
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic board_clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [FILTER_LEN-1:0]  data_dly;
  logic [CW-1:0]          cnt;
  logic                   filt;
  logic                   filt_d;

  always_ff @(posedge board_clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      data_dly  <= '1;
      cnt       <= '0;
      filt      <= 1'b1;
      filt_d    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      // Data is delayed by the filter depth so it lines up with the sample that started the edge
      data_dly  <= {data_dly[FILTER_LEN-2:0], data_sync[SYNC_STAGES-1]};
      filt_d    <= filt;
      if (clk_sync[SYNC_STAGES-1] != filt) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          filt <= clk_sync[SYNC_STAGES-1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;
  assign data = data_dly[FILTER_LEN-1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host frame receiver with E0/F0 prefix decoding
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_flag;
  logic          brk_flag;
  logic          fall;
  logic          data;
  logic          to_hit;

  ps2_clk_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .board_clk(board_clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data     (data)
  );

  // A fall in the terminal cycle takes precedence over the timeout
  assign to_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge board_clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (fall) begin
        to_cnt <= '0;
      end else if (state != IDLE && to_cnt != TW'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {data, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(PS2_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!odd_parity_ok(shift, par_bit)) begin
              parity_err <= 1'b1;
              ext_flag   <= 1'b0;
              brk_flag   <= 1'b0;
            end else if (!data) begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end else if (shift == PS2_EXT_PREFIX) begin
              ext_flag <= 1'b1;
            end else if (shift == PS2_BRK_PREFIX) begin
              brk_flag <= 1'b1;
            end else begin
              scan_code   <= shift;
              is_break    <= brk_flag;
              is_extended <= ext_flag;
              scan_valid  <= 1'b1;
              ext_flag    <= 1'b0;
              brk_flag    <= 1'b0;
            end
          end
        endcase
      end else if (to_hit) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - randomized self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 40;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       parity_err;
  logic       frame_err;

  ps2_scancode_rx #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .is_break   (is_break),
    .is_extended(is_extended),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 board_clk = ~board_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed events {is_break, is_extended, scan_code} and pulse counts
  logic [9:0] obs_q[$];
  int obs_perr = 0;
  int obs_ferr = 0;
  int obs_wide = 0;
  logic sv_prev = 1'b0;

  always @(negedge board_clk) begin
    if (scan_valid) obs_q.push_back({is_break, is_extended, scan_code});
    if (parity_err) obs_perr++;
    if (frame_err) obs_ferr++;
    if (scan_valid && sv_prev) obs_wide++;
    sv_prev = scan_valid;
  end

  // Reference model: prefix flags and the expected outcome list
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [9:0] exp_q[$];
  int exp_perr, exp_ferr, base_q, base_pe, base_fe;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cycles(HALF / 2);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      wait_cycles(HALF / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~(^b)) ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11);
    wait_cycles(60);
    if (bad_par) begin
      exp_perr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (bad_stop) begin
      exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back({m_brk, m_ext, b}); m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic begin_test();
    exp_q.delete();
    exp_perr = 0;
    exp_ferr = 0;
    base_q   = obs_q.size();
    base_pe  = obs_perr;
    base_fe  = obs_ferr;
  endtask

  task automatic test_reset();
    wait_cycles(5);
    n_checks++;
    if ({scan_code, scan_valid, is_break, is_extended, parity_err, frame_err} !== 13'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", {scan_code, scan_valid, is_break, is_extended, parity_err, frame_err});
    end
    reset = 1'b0;
    wait_cycles(30);
    n_checks++;
    if ({scan_code, scan_valid, is_break, is_extended, parity_err, frame_err} !== 13'b0) begin
      n_fail++; $display("FAIL idle_outputs: got %h, expected 0", {scan_code, scan_valid, is_break, is_extended, parity_err, frame_err});
    end
  endtask

  task automatic test_make_break_ext();
    begin_test();
    xfer(8'h1D, 0, 0);
    xfer(8'hF0, 0, 0); xfer(8'h1D, 0, 0); xfer(8'h1D, 0, 0);
    xfer(8'hE0, 0, 0); xfer(8'hF0, 0, 0); xfer(8'h75, 0, 0); xfer(8'h75, 0, 0);
    xfer(8'hE0, 0, 0); xfer(8'hE0, 0, 0); xfer(8'hE1, 0, 0);
    wait_cycles(200);
    n_checks++;
    if (obs_q.size() - base_q !== exp_q.size()) begin
      n_fail++; $display("FAIL mbe_count: got %0d events, expected %0d", obs_q.size() - base_q, exp_q.size());
    end
    foreach (exp_q[i]) if (base_q + i < obs_q.size()) begin
      n_checks++;
      if (obs_q[base_q + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mbe_event%0d: got %h, expected %h", i, obs_q[base_q + i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_perr - base_pe + obs_ferr - base_fe !== 0) begin
      n_fail++; $display("FAIL mbe_errors: got %0d error pulses, expected 0", obs_perr - base_pe + obs_ferr - base_fe);
    end
    n_checks++;
    if (scan_code !== 8'hE1) begin
      n_fail++; $display("FAIL mbe_hold: got %h, expected e1", scan_code);
    end
  endtask

  task automatic test_parity_error();
    begin_test();
    xfer(8'h1C, 1, 0);
    xfer(8'h1C, 0, 0);
    xfer(8'h33, 0, 1);
    xfer(8'h1C, 0, 0);
    n_checks++;
    if (obs_q.size() - base_q !== exp_q.size()) begin
      n_fail++; $display("FAIL par_count: got %0d events, expected %0d", obs_q.size() - base_q, exp_q.size());
    end
    foreach (exp_q[i]) if (base_q + i < obs_q.size()) begin
      n_checks++;
      if (obs_q[base_q + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL par_event%0d: got %h, expected %h", i, obs_q[base_q + i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_perr - base_pe !== exp_perr) begin
      n_fail++; $display("FAIL par_perr: got %0d, expected %0d", obs_perr - base_pe, exp_perr);
    end
    n_checks++;
    if (obs_ferr - base_fe !== exp_ferr) begin
      n_fail++; $display("FAIL par_ferr: got %0d, expected %0d", obs_ferr - base_fe, exp_ferr);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] partial;
    begin_test();
    xfer(8'hE0, 0, 0);
    partial = 8'($urandom_range(0, 255));
    send_bits({2'b11, partial, 1'b0}, 5);
    wait_cycles(TIMEOUT_CYCLES + 200);
    exp_ferr++; m_ext = 1'b0; m_brk = 1'b0;
    xfer(8'h6B, 0, 0);
    n_checks++;
    if (obs_q.size() - base_q !== exp_q.size()) begin
      n_fail++; $display("FAIL to_count: got %0d events, expected %0d", obs_q.size() - base_q, exp_q.size());
    end
    foreach (exp_q[i]) if (base_q + i < obs_q.size()) begin
      n_checks++;
      if (obs_q[base_q + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL to_event%0d: got %h, expected %h", i, obs_q[base_q + i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_ferr - base_fe !== exp_ferr) begin
      n_fail++; $display("FAIL to_ferr: got %0d, expected %0d", obs_ferr - base_fe, exp_ferr);
    end
  endtask

  task automatic test_glitch();
    begin_test();
    ps2_clk = 1'b0; wait_cycles(FILTER_LEN - 1); ps2_clk = 1'b1;
    wait_cycles(60);
    n_checks++;
    if ((obs_q.size() - base_q) + (obs_perr - base_pe) + (obs_ferr - base_fe) !== 0) begin
      n_fail++; $display("FAIL glitch_short: got %0d pulses, expected 0", (obs_q.size() - base_q) + (obs_perr - base_pe) + (obs_ferr - base_fe));
    end
    // A low of exactly FILTER_LEN samples is a real edge; data high makes it a bad start bit
    ps2_clk = 1'b0; wait_cycles(FILTER_LEN); ps2_clk = 1'b1;
    wait_cycles(60);
    n_checks++;
    if (obs_ferr - base_fe !== 1) begin
      n_fail++; $display("FAIL glitch_edge: got %0d frame errors, expected 1", obs_ferr - base_fe);
    end
  endtask

  task automatic test_reset_mid_frame();
    begin_test();
    xfer(8'hE0, 0, 0);
    send_bits({2'b11, 8'h5A, 1'b0}, 6);
    reset = 1'b1; wait_cycles(4);
    n_checks++;
    if (scan_code !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_code: got %h, expected 00", scan_code);
    end
    reset = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    wait_cycles(20);
    xfer(8'h29, 0, 0);
    n_checks++;
    if (obs_q.size() - base_q !== 1 || obs_q[obs_q.size() - 1] !== exp_q[0]) begin
      n_fail++; $display("FAIL rst_mid_event: got %0d events last %h, expected 1 event %h", obs_q.size() - base_q, obs_q[obs_q.size() - 1], exp_q[0]);
    end
    n_checks++;
    if (obs_perr - base_pe + obs_ferr - base_fe !== 0) begin
      n_fail++; $display("FAIL rst_mid_errors: got %0d, expected 0", obs_perr - base_pe + obs_ferr - base_fe);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bp, bs;
    begin_test();
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 5))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 7) == 0);
      xfer(b, bp, bs);
      wait_cycles($urandom_range(0, 100));
    end
    n_checks++;
    if (obs_q.size() - base_q !== exp_q.size()) begin
      n_fail++; $display("FAIL rnd_count: got %0d events, expected %0d", obs_q.size() - base_q, exp_q.size());
    end
    foreach (exp_q[i]) if (base_q + i < obs_q.size()) begin
      n_checks++;
      if (obs_q[base_q + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rnd_event%0d: got %h, expected %h", i, obs_q[base_q + i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_perr - base_pe !== exp_perr) begin
      n_fail++; $display("FAIL rnd_perr: got %0d, expected %0d", obs_perr - base_pe, exp_perr);
    end
    n_checks++;
    if (obs_ferr - base_fe !== exp_ferr) begin
      n_fail++; $display("FAIL rnd_ferr: got %0d, expected %0d", obs_ferr - base_fe, exp_ferr);
    end
    n_checks++;
    if (obs_wide !== 0) begin
      n_fail++; $display("FAIL pulse_width: got %0d multi-cycle scan_valid, expected 0", obs_wide);
    end
  endtask

  initial begin
    test_reset();
    test_make_break_ext();
    test_parity_error();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
